// File: rtl/timer_multi_pkg.sv
// Shared definitions for the multi-channel countdown timer: clock defaults,
// mode encoding and the prescaler width helper.
package timer_multi_pkg;

  localparam int DEF_CLK_FREQ = 25_000_000;
  localparam int SIM_TICK_DIV = 4;

  typedef enum logic {
    MODE_ONESHOT = 1'b0,
    MODE_RELOAD  = 1'b1
  } mode_e;

  // Prescaler needs at least one bit even when every edge is a tick.
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// Single countdown channel: prescaler phase, remaining count, reload value and
// mode, with a registered one-cycle expiry pulse.
module timer_channel
  import timer_multi_pkg::*;
#(
  parameter int TICK_DIV  = SIM_TICK_DIV,
  parameter int CNT_W     = 8,
  parameter int RESET_VAL = 10,
  parameter int WARN_TH   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_en,
  input  logic             i_reload,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_value,
  output logic             o_timeout,
  output logic             o_running,
  output logic             o_warn
);

  localparam int PS_W = presc_width(TICK_DIV);
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] RST_V   = CNT_W'(RESET_VAL);
  localparam logic [CNT_W-1:0] WARN_V  = CNT_W'(WARN_TH);
  localparam logic [CNT_W-1:0] ONE_V   = CNT_W'(1);

  logic [PS_W-1:0]  presc_reg, presc_next;
  logic [CNT_W-1:0] value_reg, value_next;
  logic [CNT_W-1:0] reload_val_reg, reload_val_next;
  mode_e            mode_reg, mode_next;
  logic             timeout_reg, timeout_next;

  logic value_nz;
  assign value_nz = (value_reg != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg      <= '0;
      value_reg      <= RST_V;
      reload_val_reg <= RST_V;
      mode_reg       <= MODE_ONESHOT;
      timeout_reg    <= 1'b0;
    end else begin
      presc_reg      <= presc_next;
      value_reg      <= value_next;
      reload_val_reg <= reload_val_next;
      mode_reg       <= mode_next;
      timeout_reg    <= timeout_next;
    end
  end

  always_comb begin
    presc_next      = presc_reg;
    value_next      = value_reg;
    reload_val_next = reload_val_reg;
    mode_next       = mode_reg;
    timeout_next    = 1'b0;
    if (i_start) begin
      // A start wins over a coincident tick, so no expiry is reported.
      value_next      = i_load_val;
      reload_val_next = i_load_val;
      mode_next       = i_reload ? MODE_RELOAD : MODE_ONESHOT;
      presc_next      = '0;
    end else if (i_en && value_nz) begin
      if (presc_reg == PS_LAST) begin
        presc_next = '0;
        if (value_reg == ONE_V) begin
          timeout_next = 1'b1;
          value_next   = (mode_reg == MODE_RELOAD) ? reload_val_reg : '0;
        end else begin
          value_next = value_reg - ONE_V;
        end
      end else begin
        presc_next = presc_reg + 1'b1;
      end
    end
  end

  assign o_value   = value_reg;
  assign o_timeout = timeout_reg;
  assign o_running = i_en && value_nz;
  assign o_warn    = value_nz && (value_reg <= WARN_V);

endmodule

// File: rtl/timer_multi.sv
// N_CH independent countdown channels on packed buses, plus a combined
// expiry flag for the beeper.
module timer_multi
  import timer_multi_pkg::*;
#(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int TICK_DIV  = CLK_FREQ,
  parameter int N_CH      = 4,
  parameter int CNT_W     = 8,
  parameter int RESET_VAL = 10,
  parameter int WARN_TH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       i_start,
  input  logic [N_CH-1:0]       i_en,
  input  logic [N_CH-1:0]       i_reload,
  input  logic [N_CH*CNT_W-1:0] i_load_val,
  output logic [N_CH*CNT_W-1:0] o_time_val,
  output logic [N_CH-1:0]       o_timeout,
  output logic [N_CH-1:0]       o_running,
  output logic [N_CH-1:0]       o_warn,
  output logic                  o_any_timeout
);

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      timer_channel #(
        .TICK_DIV  (TICK_DIV),
        .CNT_W     (CNT_W),
        .RESET_VAL (RESET_VAL),
        .WARN_TH   (WARN_TH)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start[gi]),
        .i_en       (i_en[gi]),
        .i_reload   (i_reload[gi]),
        .i_load_val (i_load_val[gi*CNT_W +: CNT_W]),
        .o_value    (o_time_val[gi*CNT_W +: CNT_W]),
        .o_timeout  (o_timeout[gi]),
        .o_running  (o_running[gi]),
        .o_warn     (o_warn[gi])
      );
    end
  endgenerate

  assign o_any_timeout = |o_timeout;

endmodule

// File: tb/tb_timer_multi.sv
// Directed plus random bench for timer_multi; the reference tracks enabled
// edges since each start and derives value/expiry arithmetically.
module tb_timer_multi;

  localparam int TD = 4;
  localparam int NC = 2;
  localparam int CW = 8;
  localparam int RV = 10;
  localparam int WT = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC-1:0]    i_start, i_en, i_reload;
  logic [NC*CW-1:0] i_load_val;
  logic [NC*CW-1:0] o_time_val;
  logic [NC-1:0]    o_timeout, o_running, o_warn;
  logic             o_any_timeout;

  timer_multi #(
    .CLK_FREQ  (1000),
    .TICK_DIV  (TD),
    .N_CH      (NC),
    .CNT_W     (CW),
    .RESET_VAL (RV),
    .WARN_TH   (WT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_en          (i_en),
    .i_reload      (i_reload),
    .i_load_val    (i_load_val),
    .o_time_val    (o_time_val),
    .o_timeout     (o_timeout),
    .o_running     (o_running),
    .o_warn        (o_warn),
    .o_any_timeout (o_any_timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: load value, mode, enabled edges counted since start.
  int m_load [NC];
  int m_mode [NC];
  int m_el   [NC];
  bit m_to   [NC];

  function automatic int mval(input int k);
    int n;
    if (m_load[k] == 0) return 0;
    n = m_el[k] / TD;
    if (m_mode[k] == 0) return (n >= m_load[k]) ? 0 : m_load[k] - n;
    return m_load[k] - (n % m_load[k]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      m_load[k] = RV;
      m_mode[k] = 0;
      m_el[k]   = 0;
      m_to[k]   = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NC; k++) begin
      if (i_start[k]) begin
        m_load[k] = int'(i_load_val[k*CW +: CW]);
        m_mode[k] = int'(i_reload[k]);
        m_el[k]   = 0;
        m_to[k]   = 1'b0;
      end else if (i_en[k] && mval(k) != 0) begin
        m_el[k]++;
        m_to[k] = ((m_el[k] % (m_load[k] * TD)) == 0);
      end else begin
        m_to[k] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int  v;
    logic any_exp;
    any_exp = 1'b0;
    for (int k = 0; k < NC; k++) begin
      v = mval(k);
      chk($sformatf("value[%0d]", k), 32'(o_time_val[k*CW +: CW]), 32'(v));
      chk($sformatf("timeout[%0d]", k), 32'(o_timeout[k]), 32'(m_to[k]));
      chk($sformatf("running[%0d]", k), 32'(o_running[k]), 32'(i_en[k] && v != 0));
      chk($sformatf("warn[%0d]", k), 32'(o_warn[k]), 32'(v != 0 && v <= WT));
      any_exp |= m_to[k];
    end
    chk("any_timeout", 32'(o_any_timeout), 32'(any_exp));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_ch(input int k, input int load, input bit reload);
    i_load_val[k*CW +: CW] = CW'(load);
    i_reload[k] = reload;
    i_start[k]  = 1'b1;
    step();
    i_start[k]  = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    i_start    = '0;
    i_en       = '0;
    i_reload   = '0;
    i_load_val = '0;
    model_reset();

    // Reset for three cycles, then idle with counting disabled.
    run(3);
    rst = 1'b0;
    run(2);

    // One-shot load 3 on ch0.
    i_en[0] = 1'b1;
    start_ch(0, 3, 1'b0);
    run(16);

    // Same, with a five-cycle pause after six enabled edges.
    start_ch(0, 3, 1'b0);
    run(6);
    i_en[0] = 1'b0;
    run(5);
    i_en[0] = 1'b1;
    run(14);

    // Reload mode on ch1, then reload with load 0.
    i_en[1] = 1'b1;
    start_ch(1, 2, 1'b1);
    run(24);
    start_ch(1, 0, 1'b1);
    run(10);

    // Restart on the edge that would otherwise expire ch0.
    start_ch(0, 2, 1'b0);
    run(7);
    start_ch(0, 5, 1'b0);
    run(3);

    // Simultaneous expiry on both channels.
    i_load_val = {CW'(2), CW'(2)};
    i_reload   = '0;
    i_start    = '1;
    step();
    i_start    = '0;
    run(10);

    // Asynchronous reset between clock edges while counting.
    start_ch(0, 5, 1'b0);
    run(3);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    run(2);
    #2;
    rst = 1'b0;
    run(12);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NC; k++) begin
        i_start[k]  = ($urandom_range(0, 11) == 0);
        i_en[k]     = ($urandom_range(0, 9) != 0);
        i_reload[k] = $urandom_range(0, 1) == 1;
        i_load_val[k*CW +: CW] = CW'($urandom_range(0, 6));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
